// File: rtl/seq_div_32_pkg.sv
// Shared datapath definitions: operand width, divider FSM encoding and the
// ALU opcode that selects the divide path.
package cpu_defs;

  localparam int unsigned DIV_WIDTH = 32;

  localparam logic [4:0] ALU_OP_DIV = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_div_32_div_step.sv
// One combinational restoring-division step on the {rem, quo} shift pair
// against an unsigned divisor magnitude.
module div_step
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_shift_rem = {i_rem, i_quo[WIDTH-1]};
  assign w_ge        = (w_shift_rem >= {1'b0, i_dvs});
  // rem < dvs on entry, so a successful trial always fits back into WIDTH bits
  assign w_diff      = w_shift_rem[WIDTH-1:0] - i_dvs;

  assign o_rem = w_ge ? w_diff : w_shift_rem[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_div_32.sv
// Multi-cycle signed (truncating) divider for the Z register: magnitudes are
// divided by restoring steps, then signs and the divide-by-zero result fixed up.
module seq_div_32
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] Zout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e         r_state;
  div_state_e         w_next;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs_abs;
  logic [WIDTH-1:0]   r_dvd_orig;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_dz;
  logic               r_div_by_zero;
  logic [2*WIDTH-1:0] r_zout;

  logic [WIDTH-1:0]   w_dvd_abs;
  logic [WIDTH-1:0]   w_dvs_abs;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic               w_last_step;

  // Magnitude of the most negative value wraps to itself, which is correct unsigned
  assign w_dvd_abs   = dividend[WIDTH-1] ? (-dividend) : dividend;
  assign w_dvs_abs   = divisor[WIDTH-1]  ? (-divisor)  : divisor;
  assign w_last_step = (r_count == CW'(1));
  assign w_q_fix     = r_sign_q ? (-r_quo) : r_quo;
  assign w_r_fix     = r_sign_r ? (-r_rem) : r_rem;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_dvs(r_dvs_abs),
    .o_rem(w_step_rem),
    .o_quo(w_step_quo)
  );

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last_step) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_count       <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs_abs     <= '0;
      r_dvd_orig    <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dz          <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_zout        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem      <= '0;
            r_quo      <= w_dvd_abs;
            r_dvs_abs  <= w_dvs_abs;
            r_dvd_orig <= dividend;
            r_sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r   <= dividend[WIDTH-1];
            r_dz       <= (divisor == '0);
            r_count    <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          r_rem   <= w_step_rem;
          r_quo   <= w_step_quo;
          r_count <= r_count - CW'(1);
        end
        S_FIX: begin
          r_zout        <= r_dz ? {r_dvd_orig, {WIDTH{1'b1}}} : {w_r_fix, w_q_fix};
          r_div_by_zero <= r_dz;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = r_div_by_zero;
  assign Zout        = r_zout;

endmodule

// File: tb/tb_seq_div_32.sv
// Scoreboard bench for seq_div_32: directed divides push expected results,
// a monitor pops and compares on every done pulse and checks reset/hold state.
module tb_seq_div_32;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic           Clock = 1'b0;
  logic           clear = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] Zout;

  typedef struct {
    logic [2*W-1:0] zout;
    logic           dz;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   stim_done = 1'b0;

  seq_div_32 #(.WIDTH(W)) dut (
    .Clock(Clock),
    .clear(clear),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .Zout(Zout)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] ez, input logic edz, input bit push);
    @(negedge Clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back('{ez, edz, cyc + 1});
    @(negedge Clock);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL done_timeout: done still 0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    fork
      begin : stimulus
        repeat (2) @(negedge Clock);
        clear = 1'b1;

        issue(32'h00000012, 32'h00000014, {32'h00000012, 32'h00000000}, 1'b0, 1'b1);
        wait_idle();
        issue(32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b1);
        wait_idle();
        issue(32'h00000007, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b0, 1'b1);
        wait_idle();
        issue(32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'h00000003}, 1'b0, 1'b1);
        wait_idle();
        issue(32'h00000064, 32'h00000000, {32'h00000064, 32'hFFFFFFFF}, 1'b1, 1'b1);
        wait_idle();
        issue(32'hFFFFFF9C, 32'h00000000, {32'hFFFFFF9C, 32'hFFFFFFFF}, 1'b1, 1'b1);
        wait_idle();
        issue(32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b0, 1'b1);
        wait_idle();
        issue(32'h80000000, 32'h00000001, {32'h00000000, 32'h80000000}, 1'b0, 1'b1);
        wait_idle();
        issue(32'h00000000, 32'h00000005, {32'h00000000, 32'h00000000}, 1'b0, 1'b1);
        wait_idle();

        // start during DONE is ignored; held into the following IDLE cycle it is taken
        issue(32'h000003E8, 32'h00000007, {32'h00000006, 32'h0000008E}, 1'b0, 1'b1);
        wait_done();
        dividend = 32'h00000012;
        divisor  = 32'h00000014;
        start    = 1'b1;
        sb.push_back('{{32'h00000012, 32'h00000000}, 1'b0, cyc + 2});
        repeat (2) @(negedge Clock);
        start = 1'b0;
        wait_idle();

        // second start mid-RUN must be dropped
        issue(32'h000003E8, 32'h00000007, {32'h00000006, 32'h0000008E}, 1'b0, 1'b1);
        repeat (4) @(negedge Clock);
        dividend = 32'h00000005;
        divisor  = 32'h00000005;
        start    = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        wait_idle();

        // short clear pulse between clock edges at RUN cycle 10
        issue(32'h00000012, 32'h00000014, '0, 1'b0, 1'b0);
        repeat (9) @(negedge Clock);
        @(posedge Clock);
        #1 clear = 1'b0;
        #3 clear = 1'b1;
        wait_idle();
        issue(32'h00000012, 32'h00000014, {32'h00000012, 32'h00000000}, 1'b0, 1'b1);
        wait_idle();

        repeat (3) @(negedge Clock);
        stim_done = 1'b1;
      end
      begin : monitor
        bit             prev_done = 1'b0;
        logic [2*W-1:0] last_z = '0;
        exp_t           e;
        while (!stim_done) begin
          @(negedge Clock or negedge clear);
          #1;
          if (!clear) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_dz", 64'(div_by_zero), 64'd0);
            chk("rst_zout", Zout, '0);
            last_z    = '0;
            prev_done = 1'b0;
          end else if (done) begin
            chk("done_pulse_width", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: done=1 with no outstanding request, required none");
            end else begin
              e = sb.pop_front();
              chk("zout", Zout, e.zout);
              chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
              chk("latency", 64'(cyc - e.acc), 64'(LAT));
              last_z = e.zout;
            end
            prev_done = 1'b1;
          end else begin
            chk("zout_hold", Zout, last_z);
            prev_done = 1'b0;
          end
        end
      end
    join
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
